mux_lane_arbiter: RTL and testbench

Two-lane, single-clock arbiter that sequences the 8-bit lane-0/lane-1 streams into the shared serial mux datapath. Each lane is buffered in a small FIFO; a round-robin FSM with a burst limit selects which lane feeds a registered output stage with a valid/ready handshake. It sits directly upstream of the mux/serializer and replaces free-running lane selection with fair, lossless scheduling.

---
 rtl/mux_lane_arbiter_pkg.sv | 20 ++
 rtl/mux_lane_arbiter_if.sv | 27 ++
 rtl/mux_lane_arbiter_fifo.sv | 53 +++++
 rtl/mux_lane_arbiter.sv | 143 ++++++++++++++
 tb/tb_mux_lane_arbiter.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mux_lane_arbiter_pkg.sv
// Shared types and default sizing for the two-lane mux arbiter.
package mux_arb_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_DEPTH     = 4;
  localparam int DEF_MAX_BURST = 2;

  typedef logic lane_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_t;

  function automatic arb_state_t grant_state(lane_t lane);
    return lane ? GRANT1 : GRANT0;
  endfunction

endpackage

// File: rtl/mux_lane_arbiter_if.sv
// Lane inputs and shared output handshake between the lane sources and the mux datapath.
interface mux_lane_arbiter_if
  import mux_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);
  logic [DATA_W-1:0] data_in_0;
  logic              valid_in_0;
  logic              ready_0;
  logic [DATA_W-1:0] data_in_1;
  logic              valid_in_1;
  logic              ready_1;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              ready_out;
  lane_t             sel_out;

  modport master (
    output data_in_0, valid_in_0, data_in_1, valid_in_1, ready_out,
    input  ready_0, ready_1, data_out, valid_out, sel_out
  );

  modport slave (
    input  data_in_0, valid_in_0, data_in_1, valid_in_1, ready_out,
    output ready_0, ready_1, data_out, valid_out, sel_out
  );
endinterface

// File: rtl/mux_lane_arbiter_fifo.sv
// Per-lane synchronous FIFO; storage is not reset, only pointers and occupancy.
module lane_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          din,
  output logic [DATA_W-1:0]          dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + ONE_CNT;
        2'b01:   count <= count - ONE_CNT;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/mux_lane_arbiter.sv
// Two-lane round-robin arbiter with burst limit feeding a registered valid/ready output stage.
module mux_lane_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input logic               clk,
  input logic               reset,
  mux_lane_arbiter_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
  localparam logic [BW-1:0] BURST_ONE = BW'(1);

  logic [DATA_W-1:0] dout0, dout1;
  logic              full0, full1, empty0, empty1;
  logic [CW-1:0]     count0, count1;
  logic              push0, push1, pop0, pop1;
  logic              ne0, ne1;

  arb_state_t        state;
  logic [BW-1:0]     burst;
  lane_t             last;

  arb_state_t        nxt_state;
  logic [BW-1:0]     nxt_burst;
  logic              pop_en;
  lane_t             pop_lane;
  logic              load;
  lane_t             own;
  logic              own_ne, oth_ne;

  logic [DATA_W-1:0] data_p1;
  logic              vld_p1;
  lane_t             sel_p1;

  // Occupancy is exposed by the FIFOs for debug taps; the arbiter only needs full/empty.
  logic unused_counts;
  assign unused_counts = ^{count0, count1};

  assign bus.ready_0 = reset && !full0;
  assign bus.ready_1 = reset && !full1;
  assign push0       = bus.valid_in_0 && bus.ready_0;
  assign push1       = bus.valid_in_1 && bus.ready_1;
  assign ne0         = !empty0;
  assign ne1         = !empty1;
  assign pop0        = pop_en && (pop_lane == 1'b0);
  assign pop1        = pop_en && (pop_lane == 1'b1);

  lane_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo0 (
    .clk   (clk),
    .reset (reset),
    .push  (push0),
    .pop   (pop0),
    .din   (bus.data_in_0),
    .dout  (dout0),
    .full  (full0),
    .empty (empty0),
    .count (count0)
  );

  lane_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo1 (
    .clk   (clk),
    .reset (reset),
    .push  (push1),
    .pop   (pop1),
    .din   (bus.data_in_1),
    .dout  (dout1),
    .full  (full1),
    .empty (empty1),
    .count (count1)
  );

  // Stage p0: grant decision from FIFO state, evaluated only when the output can load.
  assign load   = !vld_p1 || bus.ready_out;
  assign own    = (state == GRANT1);
  assign own_ne = own ? ne1 : ne0;
  assign oth_ne = own ? ne0 : ne1;

  always_comb begin
    nxt_state = state;
    nxt_burst = burst;
    pop_en    = 1'b0;
    pop_lane  = 1'b0;
    if (load) begin
      case (state)
        IDLE: begin
          if (ne0 || ne1) begin
            pop_en    = 1'b1;
            pop_lane  = (ne0 && ne1) ? !last : ne1;
            nxt_state = grant_state(pop_lane);
            nxt_burst = BURST_ONE;
          end
        end
        GRANT0, GRANT1: begin
          if (own_ne && ((burst < BURST_MAX) || !oth_ne)) begin
            pop_en    = 1'b1;
            pop_lane  = own;
            nxt_burst = (burst == BURST_MAX) ? BURST_MAX : burst + BURST_ONE;
          end else if (oth_ne) begin
            pop_en    = 1'b1;
            pop_lane  = !own;
            nxt_state = grant_state(!own);
            nxt_burst = BURST_ONE;
          end else begin
            nxt_state = IDLE;
          end
        end
        default: nxt_state = IDLE;
      endcase
    end
  end

  // Stage p1: FSM state and registered output word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      burst   <= '0;
      last    <= 1'b1;
      data_p1 <= '0;
      vld_p1  <= 1'b0;
      sel_p1  <= 1'b0;
    end else if (load) begin
      state <= nxt_state;
      burst <= nxt_burst;
      if (pop_en) begin
        data_p1 <= pop_lane ? dout1 : dout0;
        sel_p1  <= pop_lane;
        vld_p1  <= 1'b1;
        last    <= pop_lane;
      end else begin
        vld_p1  <= 1'b0;
      end
    end
  end

  assign bus.data_out  = data_p1;
  assign bus.valid_out = vld_p1;
  assign bus.sel_out   = sel_p1;
endmodule

// File: tb/tb_mux_lane_arbiter.sv
// Randomized and directed bench for mux_lane_arbiter against a queue-based scheduling model.
module tb_mux_lane_arbiter;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int MAXB  = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mux_lane_arbiter_if #(.DATA_W(DW)) bus ();

  mux_lane_arbiter #(.DATA_W(DW), .DEPTH(DEPTH), .MAX_BURST(MAXB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic [8:0]    obs[$];
  logic          m_vld;
  logic [DW-1:0] m_data;
  logic          m_sel;
  int            m_last;
  int            m_owner;
  int            m_run;
  bit            acc0, acc1;

  task automatic model_reset();
    q0.delete(); q1.delete();
    m_vld = 0; m_data = '0; m_sel = 0;
    m_last = 1; m_owner = -1; m_run = 0;
  endtask

  task automatic idle_inputs();
    bus.valid_in_0 = 0; bus.valid_in_1 = 0;
    bus.data_in_0 = '0; bus.data_in_1 = '0;
    bus.ready_out = 0;
  endtask

  // Advance one clock: predict from the model, step the DUT, compare.
  task automatic cycle();
    int has0, has1, lane, oth;
    bit ld;
    lane = -1;
    acc0 = bus.valid_in_0 && (q0.size() < DEPTH);
    acc1 = bus.valid_in_1 && (q1.size() < DEPTH);
    if (bus.valid_out && bus.ready_out) obs.push_back({bus.sel_out, bus.data_out});
    ld = !m_vld || bus.ready_out;
    has0 = (q0.size() > 0);
    has1 = (q1.size() > 0);
    if (ld) begin
      if (m_owner < 0) begin
        if (has0 && has1) lane = 1 - m_last;
        else if (has0) lane = 0;
        else if (has1) lane = 1;
        m_run = (lane >= 0) ? 1 : m_run;
      end else begin
        oth = 1 - m_owner;
        if (((m_owner == 0) ? has0 : has1) && (m_run < MAXB || !((oth == 0) ? has0 : has1))) begin
          lane = m_owner;
          m_run = (m_run + 1 > MAXB) ? MAXB : m_run + 1;
        end else if ((oth == 0) ? has0 : has1) begin
          lane = oth;
          m_run = 1;
        end
      end
      m_owner = lane;
      if (lane >= 0) begin
        m_data = (lane == 0) ? q0.pop_front() : q1.pop_front();
        m_sel  = lane[0];
        m_vld  = 1;
        m_last = lane;
      end else begin
        m_vld = 0;
      end
    end
    if (acc0) q0.push_back(bus.data_in_0);
    if (acc1) q1.push_back(bus.data_in_1);
    @(posedge clk); #1;
    cyc++;
    checks++;
    if (bus.valid_out !== m_vld) begin
      errors++; $display("FAIL valid_out cycle %0d: got %b expected %b", cyc, bus.valid_out, m_vld);
    end
    checks++;
    if (bus.ready_0 !== (q0.size() < DEPTH)) begin
      errors++; $display("FAIL ready_0 cycle %0d: got %b expected %b", cyc, bus.ready_0, q0.size() < DEPTH);
    end
    checks++;
    if (bus.ready_1 !== (q1.size() < DEPTH)) begin
      errors++; $display("FAIL ready_1 cycle %0d: got %b expected %b", cyc, bus.ready_1, q1.size() < DEPTH);
    end
    if (m_vld) begin
      checks++;
      if (bus.data_out !== m_data || bus.sel_out !== m_sel) begin
        errors++;
        $display("FAIL data_out cycle %0d: got %h/lane%b expected %h/lane%b", cyc, bus.data_out, bus.sel_out, m_data, m_sel);
      end
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge clk);
    reset = 0;
    model_reset();
    @(negedge clk);
    reset = 1;
    cycle();
    obs.delete();
  endtask

  task automatic collect(input int n, input string name);
    for (int c = 0; c < 60 && obs.size() < n; c++) cycle();
    checks++;
    if (obs.size() < n) begin
      errors++; $display("FAIL %s timeout: got %0d words required %0d", name, obs.size(), n);
    end
  endtask

  task automatic check_seq(input string name, input logic [8:0] exp[$]);
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (i >= obs.size() || obs[i] !== exp[i]) begin
        errors++;
        $display("FAIL %s word %0d: got %h required %h", name, i, (i < obs.size()) ? obs[i] : 9'h1xx, exp[i]);
      end
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 0;
    model_reset();
    #3;
    checks++;
    if (bus.valid_out !== 1'b0 || bus.data_out !== '0 || bus.sel_out !== 1'b0 ||
        bus.ready_0 !== 1'b0 || bus.ready_1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got v%b d%h s%b r%b%b required v0 d00 s0 r00",
               bus.valid_out, bus.data_out, bus.sel_out, bus.ready_0, bus.ready_1);
    end
    @(negedge clk);
    reset = 1;
    cycle();
    checks++;
    if (bus.ready_0 !== 1'b1 || bus.ready_1 !== 1'b1 || bus.valid_out !== 1'b0 || bus.sel_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got r%b%b v%b s%b required r11 v0 s0",
               bus.ready_0, bus.ready_1, bus.valid_out, bus.sel_out);
    end
  endtask

  task automatic test_single_lane();
    logic [8:0] exp[$];
    do_reset();
    bus.ready_out = 1;
    for (int i = 0; i < 3; i++) begin
      bus.valid_in_0 = 1;
      bus.data_in_0  = 8'h11 + 8'(i);
      cycle();
      if (i == 1) begin
        checks++;
        if (bus.valid_out !== 1'b1 || bus.data_out !== 8'h11) begin
          errors++; $display("FAIL single_latency: got v%b d%h required v1 d11", bus.valid_out, bus.data_out);
        end
      end
    end
    bus.valid_in_0 = 0;
    collect(3, "single_lane");
    exp = '{9'h011, 9'h012, 9'h013};
    check_seq("single_lane", exp);
  endtask

  task automatic test_fair();
    logic [8:0] exp[$];
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.valid_in_0 = 1; bus.data_in_0 = 8'h13 + 8'(i);
      bus.valid_in_1 = 1; bus.data_in_1 = 8'hFD - 8'(i);
      cycle();
    end
    bus.valid_in_0 = 0; bus.valid_in_1 = 0;
    bus.ready_out = 1;
    collect(8, "fair");
    exp = '{9'h013, 9'h014, 9'h1FD, 9'h1FC, 9'h015, 9'h016, 9'h1FB, 9'h1FA};
    check_seq("fair", exp);
  endtask

  task automatic test_backpressure();
    logic [8:0] exp[$];
    int idx = 0;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      bus.valid_in_1 = 1; bus.data_in_1 = 8'h40 + 8'(idx);
      cycle();
      if (acc1) idx++;
    end
    checks++;
    if (idx != 5 || bus.ready_1 !== 1'b0 || bus.data_out !== 8'h40 || bus.valid_out !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_full: got acc%0d r%b d%h v%b required acc5 r0 d40 v1",
               idx, bus.ready_1, bus.data_out, bus.valid_out);
    end
    bus.ready_out = 1;
    for (int c = 0; c < 20 && idx < 6; c++) begin
      bus.data_in_1 = 8'h40 + 8'(idx);
      cycle();
      if (acc1) idx++;
    end
    bus.valid_in_1 = 0;
    collect(6, "backpressure");
    exp = '{9'h140, 9'h141, 9'h142, 9'h143, 9'h144, 9'h145};
    check_seq("backpressure", exp);
  endtask

  task automatic test_tie();
    logic [8:0] exp[$];
    do_reset();
    bus.ready_out = 1;
    bus.valid_in_0 = 1; bus.data_in_0 = 8'h21;
    bus.valid_in_1 = 1; bus.data_in_1 = 8'h31;
    cycle();
    bus.valid_in_0 = 0; bus.valid_in_1 = 0;
    collect(2, "tie");
    exp = '{9'h021, 9'h131};
    check_seq("tie", exp);
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.valid_in_0 = 1; bus.data_in_0 = 8'h50 + 8'(i);
      cycle();
    end
    bus.valid_in_0 = 0;
    #2;
    reset = 0;
    #1;
    checks++;
    if (bus.valid_out !== 1'b0 || bus.ready_0 !== 1'b0) begin
      errors++; $display("FAIL reset_mid_async: got v%b r%b required v0 r0", bus.valid_out, bus.ready_0);
    end
    model_reset();
    @(negedge clk);
    reset = 1;
    bus.ready_out = 1;
    obs.delete();
    for (int c = 0; c < 6; c++) cycle();
    checks++;
    if (obs.size() != 0) begin
      errors++; $display("FAIL reset_mid_stale: got %0d words required 0", obs.size());
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      bus.valid_in_0 = ($urandom_range(0, 9) < 6);
      bus.valid_in_1 = ($urandom_range(0, 9) < 5);
      bus.data_in_0  = 8'($urandom);
      bus.data_in_1  = 8'($urandom);
      bus.ready_out  = ($urandom_range(0, 9) < 7);
      cycle();
    end
    idle_inputs();
    bus.ready_out = 1;
    for (int c = 0; c < 20; c++) cycle();
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    model_reset();
    test_reset();
    test_single_lane();
    test_fair();
    test_backpressure();
    test_tie();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
